// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative branch target buffer, round-robin replacement, flush
// Optional per-entry target hysteresis when BTB_HYST_EN is defined.
module btb_assoc #(
    parameter int N_SETS = 4,
    parameter int N_WAYS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_out,
    input  logic        predict,
    input  logic [31:0] pc_exec,
    input  logic [31:0] alu_out,
    input  logic        update_btb,
    input  logic        flush,
    output logic [31:0] pc_predict,
    output logic        btb_hit
);
    localparam int IDX_BITS = $clog2(N_SETS);
    localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int WAY_W    = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

    logic                r_valid  [N_SETS][N_WAYS];
    logic [TAG_BITS-1:0] r_tag    [N_SETS][N_WAYS];
    logic [31:0]         r_target [N_SETS][N_WAYS];
    logic [WAY_W-1:0]    r_rr     [N_SETS];
`ifdef BTB_HYST_EN
    logic                r_h      [N_SETS][N_WAYS];
`endif

    logic [IDX_W-1:0]    w_look_idx;
    logic [IDX_W-1:0]    w_upd_idx;
    logic [TAG_BITS-1:0] w_look_tag;
    logic [TAG_BITS-1:0] w_upd_tag;

    generate
        if (N_SETS > 1) begin : g_idx
            assign w_look_idx = pc_out[IDX_BITS+1:2];
            assign w_upd_idx  = pc_exec[IDX_BITS+1:2];
        end else begin : g_noidx
            assign w_look_idx = '0;
            assign w_upd_idx  = '0;
        end
    endgenerate

    assign w_look_tag = pc_out[31:IDX_BITS+2];
    assign w_upd_tag  = pc_exec[31:IDX_BITS+2];

    // Descending scan so the lowest matching way is the one that sticks.
    always_comb begin
        btb_hit    = 1'b0;
        pc_predict = 32'd0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (predict && r_valid[w_look_idx][w] && (r_tag[w_look_idx][w] == w_look_tag)) begin
                btb_hit    = 1'b1;
                pc_predict = r_target[w_look_idx][w];
            end
        end
    end

    logic             w_tag_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic             w_has_free;
    logic [WAY_W-1:0] w_free_way;
    logic [WAY_W-1:0] w_way;

    always_comb begin
        w_tag_hit  = 1'b0;
        w_hit_way  = '0;
        w_has_free = 1'b0;
        w_free_way = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_upd_idx][w] && (r_tag[w_upd_idx][w] == w_upd_tag)) begin
                w_tag_hit = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_upd_idx][w]) begin
                w_has_free = 1'b1;
                w_free_way = WAY_W'(w);
            end
        end
        if (w_tag_hit)       w_way = w_hit_way;
        else if (w_has_free) w_way = w_free_way;
        else                 w_way = r_rr[w_upd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < N_SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < N_WAYS; w++) begin
                    r_valid[s][w]  <= 1'b0;
                    r_tag[s][w]    <= '0;
                    r_target[s][w] <= 32'd0;
`ifdef BTB_HYST_EN
                    r_h[s][w]      <= 1'b0;
`endif
                end
            end
        end else if (flush) begin
            for (int s = 0; s < N_SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < N_WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
`ifdef BTB_HYST_EN
                    r_h[s][w]     <= 1'b0;
`endif
                end
            end
        end else if (update_btb) begin
            if (w_tag_hit) begin
`ifdef BTB_HYST_EN
                // A differing target must be seen twice in a row before it replaces the stored one.
                if (alu_out == r_target[w_upd_idx][w_way]) begin
                    r_h[w_upd_idx][w_way] <= 1'b0;
                end else if (!r_h[w_upd_idx][w_way]) begin
                    r_h[w_upd_idx][w_way] <= 1'b1;
                end else begin
                    r_target[w_upd_idx][w_way] <= alu_out;
                    r_h[w_upd_idx][w_way]      <= 1'b0;
                end
`else
                r_target[w_upd_idx][w_way] <= alu_out;
`endif
            end else begin
                r_valid[w_upd_idx][w_way]  <= 1'b1;
                r_tag[w_upd_idx][w_way]    <= w_upd_tag;
                r_target[w_upd_idx][w_way] <= alu_out;
`ifdef BTB_HYST_EN
                r_h[w_upd_idx][w_way]      <= 1'b0;
`endif
                if (!w_has_free) begin
                    if (r_rr[w_upd_idx] == WAY_W'(N_WAYS - 1)) r_rr[w_upd_idx] <= '0;
                    else                                     r_rr[w_upd_idx] <= r_rr[w_upd_idx] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// tb/tb_btb_assoc.sv - directed self-checking bench for btb_assoc (4 sets x 2 ways)
module tb_btb_assoc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_out;
    logic        predict;
    logic [31:0] pc_exec;
    logic [31:0] alu_out;
    logic        update_btb;
    logic        flush;
    logic [31:0] pc_predict;
    logic        btb_hit;

    int n_vec = 0;
    int n_err = 0;

    btb_assoc #(.N_SETS(4), .N_WAYS(2)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_out     (pc_out),
        .predict    (predict),
        .pc_exec    (pc_exec),
        .alu_out    (alu_out),
        .update_btb (update_btb),
        .flush      (flush),
        .pc_predict (pc_predict),
        .btb_hit    (btb_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_hit,
                        input logic [31:0] exp_tgt);
        pc_out  = pc;
        predict = 1'b1;
        #1;
        check({tag, "_hit"}, {31'd0, btb_hit}, {31'd0, exp_hit});
        check({tag, "_tgt"}, pc_predict, exp_tgt);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic fl);
        @(negedge clk);
        pc_exec    = pc;
        alu_out    = tgt;
        update_btb = 1'b1;
        flush      = fl;
        @(posedge clk);
        #1;
        update_btb = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pc_out = 32'd0; predict = 1'b0; pc_exec = 32'd0;
        alu_out = 32'd0; update_btb = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        look("reset", 32'h104, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        upd(32'h104, 32'h200, 1'b0);
        look("fill", 32'h104, 1'b1, 32'h200);
        predict = 1'b0;
        #1;
        check("nopredict_hit", {31'd0, btb_hit}, 32'd0);
        check("nopredict_tgt", pc_predict, 32'd0);

        // Same-cycle update and lookup: old contents this cycle, new next cycle.
        @(negedge clk);
        pc_out = 32'h104; predict = 1'b1;
        pc_exec = 32'h104; alu_out = 32'h300; update_btb = 1'b1;
        #1;
        check("samecyc_old", pc_predict, 32'h200);
        @(posedge clk);
        #1;
        update_btb = 1'b0;
`ifdef BTB_HYST_EN
        check("samecyc_new", pc_predict, 32'h200);
`else
        check("samecyc_new", pc_predict, 32'h300);
`endif

        // Replacement in set 1: 0x104 way0, 0x114 way1 (free), 0x124 evicts way0, 0x134 way1, 0x144 way0.
        upd(32'h104, 32'hA00, 1'b0);
        upd(32'h114, 32'hB00, 1'b0);
        look("nodup_104", 32'h104, 1'b1, 32'hA00);
        look("nodup_114", 32'h114, 1'b1, 32'hB00);
        upd(32'h124, 32'hC00, 1'b0);
        look("evict0_104", 32'h104, 1'b0, 32'd0);
        look("evict0_114", 32'h114, 1'b1, 32'hB00);
        upd(32'h134, 32'hD00, 1'b0);
        look("evict1_114", 32'h114, 1'b0, 32'd0);
        look("evict1_124", 32'h124, 1'b1, 32'hC00);
        look("evict1_134", 32'h134, 1'b1, 32'hD00);
        upd(32'h144, 32'hE00, 1'b0);
        look("wrap_124", 32'h124, 1'b0, 32'd0);
        look("wrap_134", 32'h134, 1'b1, 32'hD00);
        look("wrap_144", 32'h144, 1'b1, 32'hE00);

        upd(32'h208, 32'h400, 1'b0);
        look("set2_208", 32'h208, 1'b1, 32'h400);
        look("set2_keep", 32'h144, 1'b1, 32'hE00);

        upd(32'h20C, 32'h600, 1'b1);
        look("flush_134", 32'h134, 1'b0, 32'd0);
        look("flush_208", 32'h208, 1'b0, 32'd0);
        look("flush_20c", 32'h20C, 1'b0, 32'd0);

        // After flush rr is 0 and both ways free: refill and evict way0 again.
        upd(32'h104, 32'h111, 1'b0);
        upd(32'h114, 32'h222, 1'b0);
        upd(32'h124, 32'h333, 1'b0);
        look("rrclr_104", 32'h104, 1'b0, 32'd0);
        look("rrclr_114", 32'h114, 1'b1, 32'h222);

        look("pre_rst", 32'h124, 1'b1, 32'h333);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_hit", {31'd0, btb_hit}, 32'd0);
        check("async_tgt", pc_predict, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        look("post_rst", 32'h124, 1'b0, 32'd0);

        upd(32'h104, 32'h200, 1'b0);
        upd(32'h104, 32'h500, 1'b0);
`ifdef BTB_HYST_EN
        look("hyst_first", 32'h104, 1'b1, 32'h200);
`else
        look("hyst_first", 32'h104, 1'b1, 32'h500);
`endif
        upd(32'h104, 32'h500, 1'b0);
        look("hyst_second", 32'h104, 1'b1, 32'h500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
